ram_arbiter: RTL
================

# ram_arbiter

Shares the CPU's single-port 32x8 data RAM between the CPU datapath and a host port (program loader / debug access). The CPU has default priority and is stalled only while the host owns the port. A starvation counter guarantees host progress, and a burst limit bounds CPU stall time. Sits between the CPU datapath (accumulator store / memory operand path) and the `ram` instance.

## Interface
Parameters:
- AW, 5, RAM address width
- DW, 8, RAM data width
- MAX_BURST, 4, maximum consecutive host beats while the CPU is requesting (≥1)
- STARVE_LIM, 8, CPU-busy cycles a pending host waits before forced grant (≥1)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  CPU needs RAM this cycle (read operand or store)
- cpu_we_i  in  1  CPU store
- cpu_addr_i  in  AW  CPU address (instruction operand field)
- cpu_wdata_i  in  DW  accumulator value
- cpu_rdata_o  out  DW  RAM read data to ALU y-operand
- cpu_stall_o  out  1  CPU must hold PC, ACC and flags this cycle
- host_valid_i  in  1  host request valid
- host_ready_o  out  1  host request accepted this cycle
- host_we_i  in  1  host write
- host_addr_i  in  AW  host address
- host_wdata_i  in  DW  host write data
- host_rvalid_o  out  1  registered host read data valid (1-cycle pulse)
- host_rdata_o  out  DW  registered host read data
- ram_wen_o  out  1  RAM write enable
- ram_addr_o  out  AW  RAM address
- ram_din_o  out  DW  RAM write data
- ram_dout_i  in  DW  RAM asynchronous read data
- owner_o  out  1  0 = CPU owns port, 1 = host owns port

## Operation
- FSM states: S_CPU (reset state) and S_HOST. owner_o = (state == S_HOST).
- S_CPU:
  - Mux selects CPU fields; host_ready_o = 0; cpu_stall_o = 0.
  - starve_cnt increments, saturating at STARVE_LIM, on cycles with host_valid_i & cpu_req_i.
  - Next state is S_HOST if host_valid_i & (!cpu_req_i | starve_cnt == STARVE_LIM-1).
- S_HOST:
  - Mux selects host fields; host_ready_o = 1; cpu_stall_o = cpu_req_i.
  - Beat = host_valid_i & host_ready_o. beat_cnt increments per beat.
  - If !host_valid_i: go to S_CPU.
  - If a beat occurs with beat_cnt == MAX_BURST-1 and cpu_req_i = 1: go to S_CPU.
  - If a beat occurs with beat_cnt == MAX_BURST-1 and cpu_req_i = 0: stay, clear beat_cnt.
- Entering S_HOST clears starve_cnt and beat_cnt.
- ram_wen_o = rst_ni & ((S_CPU & cpu_req_i & cpu_we_i) | (S_HOST & host_valid_i & host_we_i)).
- Read paths:
  - cpu_rdata_o = ram_dout_i (combinational; valid when not stalled).
  - On a host read beat, host_rdata_o <= ram_dout_i and host_rvalid_o pulses the next cycle.
- All widths are exact; counters are sized to clog2 of their limit + 1; no address wrap handling is needed.

## Timing
- Reset (async assert, sync-safe deassert): state = S_CPU, starve_cnt = beat_cnt = 0, host_rvalid_o = 0, host_rdata_o = 0, host_ready_o = 0, cpu_stall_o = 0, owner_o = 0, ram_wen_o = 0.
- Reset mid-burst: burst abandoned, no partial write, pending read pulse dropped.
- Grant latency: at least 1 cycle from host_valid_i rise to host_ready_o (registered ownership). A host that is idle-granted sees ready on the next edge.
- Host read latency: 1 cycle (accept edge, then host_rvalid_o).
- Host write completes at the accept edge.
- Host may drop host_valid_i at any time; no beat occurs in that cycle and ownership returns to the CPU next cycle.
- Worst-case CPU stall while requesting: MAX_BURST cycles.
- Worst-case host wait under continuous cpu_req_i: STARVE_LIM cycles + 1.
- Simultaneous cpu_req_i and host_valid_i in S_CPU: CPU wins unless starve_cnt == STARVE_LIM-1.

## Structure
- Shared header `arb_defs.vh`: state encodings S_CPU/S_HOST and the default MAX_BURST/STARVE_LIM values, included like the other CPU modules.
- One natural sub-module, `sat_counter` (parameterised width/limit, clear, increment, saturate), instantiated for starve_cnt and beat_cnt.
- Port mux and write-enable logic stay inline.

## Test plan
- Reset with host_valid_i = 1 and cpu_req_i = 1 → all outputs at reset values, ram_wen_o = 0; after release, CPU store of 0x5A to addr 3 is written in the first cycle.
- CPU idle, host writes 0x11..0x14 to addr 0..3 back-to-back → ready on cycle 2, 4 beats accepted, RAM contents match, owner_o returns to 0 one cycle after valid drops.
- Host read of addr 3 after CPU store 0x5A → host_rvalid_o pulses 1 cycle after accept with host_rdata_o = 0x5A.
- cpu_req_i held high, host_valid_i high → host granted after exactly STARVE_LIM CPU cycles, cpu_stall_o high for MAX_BURST = 4 cycles, then CPU resumes.
- Host burst of 6 with cpu_req_i low throughout → all 6 beats accepted without ownership change; cpu_stall_o stays 0.
- Async reset asserted mid host burst (beat 2) → next beat is not written, state = S_CPU, host_rvalid_o = 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter shared types: FSM state encoding,
// default burst/starvation limits, counter sizing.
package ram_arbiter_pkg;

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } arb_state_e;

  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_STARVE_LIM = 8;

  function automatic int cnt_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_sat_counter.sv
// sat_counter: up-counter with sync clear, saturating at LIM.
// Ports: clk_i, rst_ni, clr_i, inc_i -> cnt_o[W-1:0].
module sat_counter #(
  parameter int W   = 4,
  parameter int LIM = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] TOP = W'(LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != TOP)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: CPU default owner, host port
// with starvation grant, burst limit, registered read data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          host_valid_i,
  output logic          host_ready_o,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_rvalid_o,
  output logic [DW-1:0] host_rdata_o,
  output logic          ram_wen_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i,
  output logic          owner_o
);

  localparam int SW = cnt_w(STARVE_LIM);
  localparam int BW = cnt_w(MAX_BURST);
  localparam logic [SW-1:0] STARVE_LAST =
    SW'(STARVE_LIM - 1);
  localparam logic [BW-1:0] BURST_LAST =
    BW'(MAX_BURST - 1);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic          in_host;
  logic          beat;
  logic          burst_end;
  logic          enter_host;
  logic          rd_beat;

  assign in_host    = (state_q == S_HOST);
  assign beat       = in_host & host_valid_i;
  assign burst_end  = beat & (beat_cnt == BURST_LAST);
  assign enter_host = ~in_host & (state_d == S_HOST);
  assign rd_beat    = beat & ~host_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // CPU keeps the port on a tie unless the host has
  // waited long enough; a burst hands back only when
  // the CPU is actually asking for the port.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CPU: begin
        if (host_valid_i &
            (~cpu_req_i | (starve_cnt == STARVE_LAST)))
          state_d = S_HOST;
      end
      S_HOST: begin
        if (!host_valid_i)
          state_d = S_CPU;
        else if (burst_end & cpu_req_i)
          state_d = S_CPU;
      end
      default: state_d = S_CPU;
    endcase
  end

  always_comb begin
    host_ready_o = 1'b0;
    cpu_stall_o  = 1'b0;
    owner_o      = 1'b0;
    ram_addr_o   = cpu_addr_i;
    ram_din_o    = cpu_wdata_i;
    ram_wen_o    = rst_ni & cpu_req_i & cpu_we_i;
    unique case (state_q)
      S_CPU: begin
      end
      S_HOST: begin
        host_ready_o = 1'b1;
        cpu_stall_o  = cpu_req_i;
        owner_o      = 1'b1;
        ram_addr_o   = host_addr_i;
        ram_din_o    = host_wdata_i;
        ram_wen_o    = rst_ni & host_valid_i & host_we_i;
      end
      default: begin
      end
    endcase
  end

  sat_counter #(
    .W   (SW),
    .LIM (STARVE_LIM)
  ) u_starve (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (enter_host),
    .inc_i  (~in_host & host_valid_i & cpu_req_i),
    .cnt_o  (starve_cnt)
  );

  // An idle CPU lets the host keep streaming; the beat
  // window restarts so a later CPU request is bounded.
  sat_counter #(
    .W   (BW),
    .LIM (MAX_BURST)
  ) u_beat (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (enter_host | (burst_end & ~cpu_req_i)),
    .inc_i  (beat),
    .cnt_o  (beat_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
    end else begin
      host_rvalid_o <= rd_beat;
      if (rd_beat) begin
        host_rdata_o <= ram_dout_i;
      end
    end
  end

  assign cpu_rdata_o = ram_dout_i;

endmodule
